stall_detection_unit: RTL and testbench

Hazard stall controller for the five-stage MIPS pipeline, sitting alongside the forwarding unit in the datapath control. It compares the source-register demand of the instruction in D against results still in flight in E and M. When no bypass path can deliver a value in time, it freezes F/D and inserts a bubble into E. It also owns the HI/LO multiply/divide busy counter and a saturating stall-cycle performance counter.

---
 rtl/mips_defs_pkg.sv | 67 ++++++
 rtl/stall_detection_unit_decoder.sv | 82 ++++++++
 rtl/stall_detection_unit.sv | 85 ++++++++
 tb/tb_stall_detection_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - MIPS opcode/funct constants, field ranges and hazard timing values
package mips_defs;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1a, FN_DIVU = 6'h1b;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR   = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0] CP0_MF = 5'h00;
  localparam logic [4:0] CP0_MT = 5'h04;

  // A source that is not read gets TUSE_NONE so no Tnew (max 2) can exceed it.
  localparam logic [1:0] T_0       = 2'd0;
  localparam logic [1:0] T_1       = 2'd1;
  localparam logic [1:0] T_2       = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic cal_r;
    logic cal_s;
    logic cal_il;
    logic cal_ia;
    logic load;
    logic store;
    logic b_cmp;
    logic b_cmpz;
    logic jr;
    logic jalr;
    logic jal;
    logic mult_div;
    logic md_div;
    logic mf;
    logic mt;
    logic mfc0;
    logic mtc0;
  } instr_class_t;

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tnew != T_0) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/stall_detection_unit_decoder.sv
// rtl/stall_detection_unit_decoder.sv - instruction class, register fields and Tnew/Tuse per stage
module Instruction_Decoder
  import mips_defs::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   dest,
  output logic [1:0]   tuse_rs,
  output logic [1:0]   tuse_rt,
  output logic [1:0]   tnew_e,
  output logic [1:0]   tnew_m
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op = instr[OP_MSB:OP_LSB];
  assign fn = instr[FN_MSB:FN_LSB];
  assign rs = instr[RS_MSB:RS_LSB];
  assign rt = instr[RT_MSB:RT_LSB];
  assign rd = instr[RD_MSB:RD_LSB];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    cls = '0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: cls.cal_r = 1'b1;
          FN_SLL, FN_SRL, FN_SRA:                      cls.cal_s = 1'b1;
          FN_JR:                                       cls.jr    = 1'b1;
          FN_JALR:                                     cls.jalr  = 1'b1;
          FN_MULT, FN_MULTU:                           cls.mult_div = 1'b1;
          FN_DIV, FN_DIVU: begin
            cls.mult_div = 1'b1;
            cls.md_div   = 1'b1;
          end
          FN_MFHI, FN_MFLO:                            cls.mf = 1'b1;
          FN_MTHI, FN_MTLO:                            cls.mt = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ:                     cls.b_cmpz = 1'b1;
      OP_BEQ, OP_BNE:                                  cls.b_cmp  = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:            cls.cal_ia = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                cls.cal_il = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:             cls.load   = 1'b1;
      OP_SB, OP_SH, OP_SW:                             cls.store  = 1'b1;
      OP_JAL:                                          cls.jal    = 1'b1;
      OP_COP0: begin
        cls.mfc0 = (rs == CP0_MF);
        cls.mtc0 = (rs == CP0_MT);
      end
      default: ;
    endcase
  end

  always_comb begin
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    tnew_e  = T_0;
    tnew_m  = T_0;
    dest    = 5'd0;
    if (cls.b_cmp || cls.b_cmpz || cls.jr || cls.jalr) tuse_rs = T_0;
    else if (cls.cal_r || cls.cal_il || cls.cal_ia || cls.load || cls.store) tuse_rs = T_1;
    if (cls.b_cmp) tuse_rt = T_0;
    else if (cls.cal_r || cls.cal_s) tuse_rt = T_1;
    else if (cls.store || cls.mtc0) tuse_rt = T_2;
    if (cls.cal_r || cls.cal_s || cls.cal_il || cls.cal_ia || cls.mf) tnew_e = T_1;
    else if (cls.load || cls.mfc0) tnew_e = T_2;
    if (cls.load || cls.mfc0) tnew_m = T_1;
    if (cls.cal_r || cls.cal_s || cls.mf || cls.jalr) dest = rd;
    else if (cls.cal_il || cls.cal_ia || cls.load || cls.mfc0) dest = rt;
    else if (cls.jal) dest = 5'd31;
  end

endmodule

// File: rtl/stall_detection_unit.sv
// rtl/stall_detection_unit.sv - D-stage hazard stall, HI/LO busy counter and stall-cycle counter
module stall_detection_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrD,
  input  logic [31:0]      InstrE,
  input  logic [31:0]      InstrM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MD_W = $clog2(DIV_CYCLES + 1);

  instr_class_t cls_d, cls_e, cls_m;
  logic [4:0]   rs_d, rt_d, dest_d, rs_e, rt_e, dest_e, rs_m, rt_m, dest_m;
  logic [1:0]   tuse_rs_d, tuse_rt_d, tnew_e_d, tnew_m_d;
  logic [1:0]   tuse_rs_e, tuse_rt_e, tnew_e_e, tnew_m_e;
  logic [1:0]   tuse_rs_m, tuse_rt_m, tnew_e_m, tnew_m_m;

  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             data_stall, md_stall, stall, md_busy;
  logic             unused_dec;

  Instruction_Decoder u_dec_d (
    .instr(InstrD), .cls(cls_d), .rs(rs_d), .rt(rt_d), .dest(dest_d),
    .tuse_rs(tuse_rs_d), .tuse_rt(tuse_rt_d), .tnew_e(tnew_e_d), .tnew_m(tnew_m_d)
  );
  Instruction_Decoder u_dec_e (
    .instr(InstrE), .cls(cls_e), .rs(rs_e), .rt(rt_e), .dest(dest_e),
    .tuse_rs(tuse_rs_e), .tuse_rt(tuse_rt_e), .tnew_e(tnew_e_e), .tnew_m(tnew_m_e)
  );
  Instruction_Decoder u_dec_m (
    .instr(InstrM), .cls(cls_m), .rs(rs_m), .rt(rt_m), .dest(dest_m),
    .tuse_rs(tuse_rs_m), .tuse_rt(tuse_rt_m), .tnew_e(tnew_e_m), .tnew_m(tnew_m_m)
  );

  // Each stage decoder produces the full set; only the stage-relevant fields are consumed.
  assign unused_dec = ^{dest_d, tnew_e_d, tnew_m_d, cls_d, rs_e, rt_e, tuse_rs_e, tuse_rt_e,
                        tnew_m_e, cls_e, rs_m, rt_m, tuse_rs_m, tuse_rt_m, tnew_e_m, cls_m};

  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    data_stall = src_hazard(rs_d, tuse_rs_d, dest_e, tnew_e_e)
               | src_hazard(rs_d, tuse_rs_d, dest_m, tnew_m_m)
               | src_hazard(rt_d, tuse_rt_d, dest_e, tnew_e_e)
               | src_hazard(rt_d, tuse_rt_d, dest_m, tnew_m_m);
    md_stall   = (cls_d.mult_div | cls_d.mf | cls_d.mt) & (md_busy | cls_e.mult_div);
    stall      = data_stall | md_stall;

    md_cnt_d = md_cnt_q;
    if (cls_e.mult_div) md_cnt_d = cls_e.md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    else if (md_busy)   md_cnt_d = md_cnt_q - 1'b1;

    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = stall;
  assign MdBusy     = md_busy;
  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_stall_detection_unit.sv
// tb/tb_stall_detection_unit.sv - randomized and directed checks against a class-level pipeline model
module tb_stall_detection_unit;

  typedef enum int {
    C_NOP, C_CALR, C_CALS, C_CALIL, C_CALIA, C_LOAD, C_STORE, C_BCMP, C_BCMPZ,
    C_JR, C_JALR, C_JAL, C_MD, C_MF, C_MT, C_MFC0, C_MTC0
  } cls_t;

  typedef struct {
    cls_t cls;
    int   rs;
    int   rt;
    int   rd;
    int   sel;
  } ent_t;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, instr_e, instr_m;
  logic        stall_f, stall_d, flush_e, md_busy;
  logic [31:0] stall_count;
  logic        s4_f, s4_d, s4_fl, busy4;
  logic [3:0]  stall_count4;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t pd, pe, pm;
  ent_t fq[$];
  bit   rnd_mode = 0;
  int   cyc = 0;
  int   busy_until = -1;
  int   scount = 0;
  bit   obs_stall, obs_flush, obs_busy;
  int   obs_count, obs_count4;

  always #5 clk = ~clk;

  stall_detection_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .InstrD(instr_d), .InstrE(instr_e), .InstrM(instr_m),
    .StallF(stall_f), .StallD(stall_d), .FlushE(flush_e), .MdBusy(md_busy), .StallCount(stall_count)
  );

  stall_detection_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .InstrD(instr_d), .InstrE(instr_e), .InstrM(instr_m),
    .StallF(s4_f), .StallD(s4_d), .FlushE(s4_fl), .MdBusy(busy4), .StallCount(stall_count4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ent_t mk(input cls_t c, input int rs, input int rt, input int rd, input int sel);
    ent_t x;
    x.cls = c; x.rs = rs; x.rt = rt; x.rd = rd; x.sel = sel;
    return x;
  endfunction

  function automatic logic [31:0] enc(input ent_t x);
    logic [4:0] s, t, d;
    logic [5:0] v;
    s = 5'(x.rs); t = 5'(x.rt); d = 5'(x.rd);
    case (x.cls)
      C_CALR: begin
        case (x.sel % 6)
          0: v = 6'h21; 1: v = 6'h23; 2: v = 6'h24; 3: v = 6'h25; 4: v = 6'h2a; default: v = 6'h2b;
        endcase
        return {6'h00, s, t, d, 5'd0, v};
      end
      C_CALS:  return {6'h00, s, t, d, 5'(x.sel), (x.sel % 3 == 0) ? 6'h00 : (x.sel % 3 == 1) ? 6'h02 : 6'h03};
      C_CALIL: return {6'h0c + 6'(x.sel % 3), s, t, 16'h1234};
      C_CALIA: return {6'h08 + 6'(x.sel % 4), s, t, 16'hfff0};
      C_LOAD:  return {(x.sel % 3 == 0) ? 6'h23 : (x.sel % 3 == 1) ? 6'h20 : 6'h25, s, t, 16'h0010};
      C_STORE: return {(x.sel % 3 == 0) ? 6'h2b : (x.sel % 3 == 1) ? 6'h28 : 6'h29, s, t, 16'h0020};
      C_BCMP:  return {(x.sel % 2 == 0) ? 6'h04 : 6'h05, s, t, 16'h0004};
      C_BCMPZ: begin
        if (x.sel % 3 == 2) return {6'h01, s, 5'(x.sel % 2), 16'h0004};
        return {(x.sel % 3 == 0) ? 6'h06 : 6'h07, s, t, 16'h0004};
      end
      C_JR:    return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h08};
      C_JALR:  return {6'h00, s, 5'd0, d, 5'd0, 6'h09};
      C_JAL:   return {6'h03, 26'h0000100};
      C_MD:    return {6'h00, s, t, 10'd0, 6'h18 + 6'(x.sel % 4)};
      C_MF:    return {6'h00, 10'd0, d, 5'd0, (x.sel % 2 == 1) ? 6'h12 : 6'h10};
      C_MT:    return {6'h00, s, 15'd0, (x.sel % 2 == 1) ? 6'h13 : 6'h11};
      C_MFC0:  return {6'h10, 5'h00, t, d, 11'd0};
      C_MTC0:  return {6'h10, 5'h04, t, d, 11'd0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_div(input ent_t x);
    return (x.cls == C_MD) && ((x.sel % 4) >= 2);
  endfunction

  function automatic int dest_of(input ent_t x);
    if (x.cls inside {C_CALR, C_CALS, C_MF, C_JALR}) return x.rd;
    if (x.cls inside {C_CALIL, C_CALIA, C_LOAD, C_MFC0}) return x.rt;
    if (x.cls == C_JAL) return 31;
    return 0;
  endfunction

  function automatic int tnew_in_e(input ent_t x);
    if (x.cls inside {C_CALR, C_CALS, C_CALIL, C_CALIA, C_MF}) return 1;
    if (x.cls inside {C_LOAD, C_MFC0}) return 2;
    return 0;
  endfunction

  function automatic int tnew_in_m(input ent_t x);
    return (x.cls inside {C_LOAD, C_MFC0}) ? 1 : 0;
  endfunction

  function automatic int tuse_rs(input ent_t x);
    if (x.cls inside {C_BCMP, C_BCMPZ, C_JR, C_JALR}) return 0;
    if (x.cls inside {C_CALR, C_CALIL, C_CALIA, C_LOAD, C_STORE}) return 1;
    return 99;
  endfunction

  function automatic int tuse_rt(input ent_t x);
    if (x.cls == C_BCMP) return 0;
    if (x.cls inside {C_CALR, C_CALS}) return 1;
    if (x.cls inside {C_STORE, C_MTC0}) return 2;
    return 99;
  endfunction

  function automatic bit waits_on(input int src, input int tuse, input int dst, input int tnew);
    return (src != 0) && (src == dst) && (tnew > 0) && (tnew > tuse);
  endfunction

  function automatic bit model_stall(input ent_t d, input ent_t e, input ent_t m, input bit busy);
    bit ds;
    ds = waits_on(d.rs, tuse_rs(d), dest_of(e), tnew_in_e(e)) || waits_on(d.rs, tuse_rs(d), dest_of(m), tnew_in_m(m))
      || waits_on(d.rt, tuse_rt(d), dest_of(e), tnew_in_e(e)) || waits_on(d.rt, tuse_rt(d), dest_of(m), tnew_in_m(m));
    return ds || ((d.cls inside {C_MD, C_MF, C_MT}) && (busy || e.cls == C_MD));
  endfunction

  function automatic int rreg();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 31 : r % 4;
  endfunction

  function automatic ent_t gen_random();
    return mk(cls_t'($urandom_range(0, 16)), rreg(), rreg(), rreg(), $urandom_range(0, 5));
  endfunction

  function automatic ent_t next_fetch();
    if (fq.size() > 0) return fq.pop_front();
    if (rnd_mode) return gen_random();
    return mk(C_NOP, 0, 0, 0, 0);
  endfunction

  task automatic run_cycle(input bit do_rst);
    bit es, eb;
    @(negedge clk);
    reset   = !do_rst;
    instr_d = enc(pd);
    instr_e = enc(pe);
    instr_m = enc(pm);
    #1;
    eb = (cyc <= busy_until);
    es = model_stall(pd, pe, pm, eb);
    check_eq("stall_f", stall_f, es);
    check_eq("stall_d", stall_d, es);
    check_eq("flush_e", flush_e, es);
    check_eq("md_busy", md_busy, eb);
    check_eq("stall_count", stall_count, scount);
    check_eq("dut4_ctl", {s4_f, s4_d, s4_fl, busy4}, {es, es, es, eb});
    check_eq("stall_count_sat", stall_count4, (scount > 15) ? 15 : scount);
    obs_stall  = stall_f;
    obs_flush  = flush_e;
    obs_busy   = md_busy;
    obs_count  = stall_count;
    obs_count4 = stall_count4;
    @(posedge clk);
    if (do_rst) begin
      scount     = 0;
      busy_until = cyc;
    end else begin
      if (es) scount++;
      if (pe.cls == C_MD) busy_until = cyc + (is_div(pe) ? DIV_N : MULT_N);
    end
    pm = pe;
    if (es) pe = mk(C_NOP, 0, 0, 0, 0);
    else begin
      pe = pd;
      pd = next_fetch();
    end
    cyc++;
  endtask

  task automatic start_test(input ent_t d, input ent_t e, input ent_t m);
    rnd_mode = 0;
    fq.delete();
    pd = mk(C_NOP, 0, 0, 0, 0); pe = pd; pm = pd;
    run_cycle(1);
    pd = d; pe = e; pm = m;
  endtask

  initial begin
    bit hs[16];
    bit hb[16];
    ent_t nop;
    nop = mk(C_NOP, 0, 0, 0, 0);
    pd = nop; pe = nop; pm = nop;
    reset = 1'b0; instr_d = '0; instr_e = '0; instr_m = '0;
    repeat (2) @(posedge clk);
    busy_until = -1;

    // reset state
    run_cycle(1);
    run_cycle(0);
    check_eq("reset_busy", obs_busy, 0);
    check_eq("reset_count", obs_count, 0);

    // lw $1 in E, addu $2,$1,$3 in D: one stall
    start_test(mk(C_CALR, 1, 3, 2, 0), mk(C_LOAD, 0, 1, 0, 0), nop);
    for (int i = 0; i < 3; i++) begin run_cycle(0); hs[i] = obs_stall; end
    check_eq("lw_calr_c0", hs[0], 1);
    check_eq("lw_calr_c1", hs[1], 0);
    check_eq("lw_calr_count", obs_count, 1);

    // lw $1 in E, beq $1,$2 in D: two stalls with bubbles
    start_test(mk(C_BCMP, 1, 2, 0, 0), mk(C_LOAD, 0, 1, 0, 0), nop);
    for (int i = 0; i < 3; i++) begin run_cycle(0); hs[i] = obs_stall; hb[i] = obs_flush; end
    check_eq("lw_beq_stall", {hs[0], hs[1], hs[2]}, 3'b110);
    check_eq("lw_beq_flush", {hb[0], hb[1]}, 2'b11);

    // cal in E feeding a branch: one stall
    start_test(mk(C_BCMP, 2, 0, 0, 1), mk(C_CALIA, 1, 2, 0, 1), nop);
    for (int i = 0; i < 2; i++) begin run_cycle(0); hs[i] = obs_stall; end
    check_eq("cal_beq_stall", {hs[0], hs[1]}, 2'b10);

    // $0 exempt; jal feeding jr $31 needs no stall
    start_test(mk(C_BCMP, 0, 0, 0, 0), mk(C_CALR, 4, 5, 0, 0), nop);
    run_cycle(0);
    check_eq("zero_reg", obs_stall, 0);
    start_test(mk(C_JR, 31, 0, 0, 0), mk(C_JAL, 0, 0, 0, 0), nop);
    run_cycle(0);
    check_eq("jal_jr", obs_stall, 0);

    // mult in E with mflo in D
    start_test(mk(C_MF, 0, 0, 3, 1), mk(C_MD, 1, 2, 0, 0), nop);
    for (int i = 0; i < 8; i++) begin run_cycle(0); hs[i] = obs_stall; hb[i] = obs_busy; end
    for (int i = 0; i < 8; i++) begin
      check_eq("mult_stall", hs[i], (i <= MULT_N) ? 1 : 0);
      check_eq("mult_busy", hb[i], (i >= 1 && i <= MULT_N) ? 1 : 0);
    end

    // div in E with mfhi in D
    start_test(mk(C_MF, 0, 0, 3, 0), mk(C_MD, 1, 2, 0, 2), nop);
    for (int i = 0; i < 13; i++) begin run_cycle(0); hs[i] = obs_stall; hb[i] = obs_busy; end
    for (int i = 0; i < 13; i++) begin
      check_eq("div_stall", hs[i], (i <= DIV_N) ? 1 : 0);
      check_eq("div_busy", hb[i], (i >= 1 && i <= DIV_N) ? 1 : 0);
    end

    // reset two cycles after mult clears busy and count
    start_test(mk(C_MF, 0, 0, 3, 1), mk(C_MD, 1, 2, 0, 1), nop);
    run_cycle(0);
    run_cycle(0);
    check_eq("mid_reset_busy_pre", obs_busy, 1);
    run_cycle(1);
    check_eq("mid_reset_count_pre", obs_count, 2);
    run_cycle(0);
    check_eq("mid_reset_busy", obs_busy, 0);
    check_eq("mid_reset_count", obs_count, 0);
    check_eq("mid_reset_nostall", obs_stall, 0);

    // back-to-back divides push the 4-bit counter into saturation
    start_test(mk(C_MF, 0, 0, 3, 0), mk(C_MD, 1, 2, 0, 2), nop);
    fq.push_back(mk(C_MD, 1, 2, 0, 3));
    fq.push_back(mk(C_MF, 0, 0, 3, 0));
    for (int i = 0; i < 30; i++) run_cycle(0);
    check_eq("sat_full_count", obs_count, 22);
    check_eq("sat_4bit_count", obs_count4, 15);

    // randomized traffic with occasional reset
    start_test(nop, nop, nop);
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) run_cycle($urandom_range(0, 299) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
